// File: rtl/aes_encipher.sv
// Iterative AES-128/AES-256 forward cipher, one round per clock.
// Round keys come from an external key store indexed by the round output.
module aes_encipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;
  localparam logic [RND_W-1:0] NR_128 = RND_W'(10);
  localparam logic [RND_W-1:0] NR_256 = RND_W'(14);

  // Forward S-box, byte x stored at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, INIT, MAIN} state_e;

  state_e           state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             keylen_q, keylen_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic             ready_q, ready_d;

  logic [BLK_W-1:0] sr_c;
  logic [BLK_W-1:0] mc_c;
  logic [RND_W-1:0] nr_c;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes + ShiftRows: byte (row r, col c) takes the S-box of (r, c+r mod 4).
  function automatic logic [BLK_W-1:0] sub_shift(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[(15 - (4*c + r))*8 +: 8] = sbox(s[(15 - (4*((c + r) % 4) + r))*8 +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[(15 - 4*c)*8 +: 8];
      a1 = s[(14 - 4*c)*8 +: 8];
      a2 = s[(13 - 4*c)*8 +: 8];
      a3 = s[(12 - 4*c)*8 +: 8];
      o[(15 - 4*c)*8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[(14 - 4*c)*8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[(13 - 4*c)*8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[(12 - 4*c)*8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  assign sr_c = sub_shift(block_q);
  assign mc_c = mix_columns(sr_c);
  assign nr_c = keylen_q ? NR_256 : NR_128;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= '0;
      keylen_q <= 1'b0;
      block_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      keylen_q <= keylen_d;
      block_q  <= block_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    keylen_d = keylen_q;
    block_d  = block_q;
    ready_d  = ready_q;
    unique case (state_q)
      IDLE: begin
        if (next) begin
          block_d  = block;
          keylen_d = keylen;
          ready_d  = 1'b0;
          round_d  = '0;
          state_d  = INIT;
        end
      end
      INIT: begin
        block_d = block_q ^ round_key;
        round_d = RND_W'(1);
        state_d = MAIN;
      end
      MAIN: begin
        // Final round omits MixColumns and hands the result back to IDLE.
        if (round_q == nr_c) begin
          block_d = sr_c ^ round_key;
          round_d = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          block_d = mc_c ^ round_key;
          round_d = round_q + RND_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher.sv
// Directed FIPS-197 vectors for aes_encipher with a bench-side key store
// whose S-box is derived from GF(2^8) inversion rather than a table.
module tb_aes_encipher;

  logic         clk;
  logic         rst_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [127:0] rk [0:15];
  logic [7:0]   sb [0:255];
  int errors;
  int checks;

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign round_key = rk[round];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic load_keys(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    int nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = 128'h0;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request; {ready,round} is checked after every edge.
  task automatic run(input string tag, input logic [255:0] key, input logic kl,
                     input logic [127:0] pt, input logic [127:0] ct, input bit disturb);
    int nr;
    nr = kl ? 14 : 10;
    load_keys(key, kl);
    block  = pt;
    keylen = kl;
    next   = 1'b1;
    chk({tag, " idle round"}, 128'(round), 128'(0));
    @(posedge clk); #1;
    chk({tag, " init"}, 128'({ready, round}), 128'(5'd0));
    next = disturb;
    for (int i = 1; i <= nr; i++) begin
      @(posedge clk); #1;
      chk({tag, " trace"}, 128'({ready, round}), 128'({1'b0, 4'(i)}));
      if (disturb) begin
        next   = ~next;
        keylen = ~keylen;
        block  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    @(posedge clk); #1;
    next = 1'b0;
    chk({tag, " done"}, 128'({ready, round}), 128'(5'h10));
    chk({tag, " ct"}, new_block, ct);
    @(posedge clk); #1;
    chk({tag, " hold"}, 128'({ready, round}), 128'(5'h10));
    chk({tag, " hold ct"}, new_block, ct);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    next   = 1'b0;
    keylen = 1'b0;
    block  = 128'h0;
    for (int r = 0; r < 16; r++) rk[r] = 128'h0;
    for (int a = 0; a < 256; a++) sb[a] = sbox_calc(8'(a));

    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 128'({ready, round}), 128'(0));
    chk("reset block", new_block, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("C1", KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);
    run("AppB", KEY_B, 1'b0, PT_B, CT_B, 1'b0);
    run("C3", KEY_C3, 1'b1, PT_C, CT_C3, 1'b0);
    run("C1 disturbed", KEY_C1, 1'b0, PT_C, CT_C1, 1'b1);

    // Back-to-back with next held high: C.1 then Appendix B, 12 cycles apart.
    load_keys(KEY_C1, 1'b0);
    block  = PT_C;
    keylen = 1'b0;
    next   = 1'b1;
    @(posedge clk); #1;
    block = PT_B;
    repeat (10) @(posedge clk);
    #1;
    chk("b2b first pending", 128'({ready, round}), 128'(5'd10));
    @(posedge clk); #1;
    chk("b2b first ready", 128'(ready), 128'(1));
    chk("b2b first ct", new_block, CT_C1);
    load_keys(KEY_B, 1'b0);
    @(posedge clk); #1;
    chk("b2b first ready pulse", 128'({ready, round}), 128'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("b2b second pending", 128'({ready, round}), 128'(5'd10));
    @(posedge clk); #1;
    chk("b2b second ready", 128'(ready), 128'(1));
    chk("b2b second ct", new_block, CT_B);
    @(posedge clk); #1;
    chk("b2b second ready pulse", 128'({ready, round}), 128'(0));
    next = 1'b0;

    // The third request started above is reset at round 5.
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset round", 128'({ready, round}), 128'(5'd5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset state", 128'({ready, round}), 128'(0));
    chk("mid reset block", new_block, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("C1 after reset", KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
